wallace_mult_pipe: RTL and testbench
====================================

// Module: wallace_mult_pipe
// PURPOSE
//  Parametrised, pipelined Wallace-tree multiplier; successor to the fixed 5x5 combinational tree.
//  Accepts one operand pair per cycle over a valid/ready handshake.
//  Supports unsigned or signed (two's complement) per transaction and fixed 3-cycle latency.
//  Output stalls under backpressure. Sits between operand source and accumulator/datapath consumers.
// PARAMETERS
//  WIDTH    8   operand width in bits; legal range 2..16
//  PW       2*WIDTH   product width; derived localparam, not overridable
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       block can accept operands this cycle
//  in_signed  in   1       1: a,b two's complement; 0: unsigned; sampled with operands
//  in_a       in   WIDTH   multiplicand
//  in_b       in   WIDTH   multiplier
//  out_valid  out  1       product valid
//  out_ready  in   1       consumer accepts product this cycle
//  out_prod   out  PW      product, exact (no truncation, no overflow possible)
// BEHAVIOUR
//  - Reset (async assert, sync-released by the system): all stage valid bits 0, all data regs 0.
//    out_valid=0, out_prod=0, in_ready=1.
//  - Global enable adv = !out_valid | out_ready. in_ready = adv (combinational, no in_valid dependency).
//  - Accept when in_valid & in_ready. Capture a, b and in_signed into S1.
//  - Pipeline, all registers update only when adv=1:
//    S1: partial-product matrix. Signed mode uses Baugh-Wooley, i.e. inverted MSB-row/column terms
//        plus constant 1s at columns WIDTH and PW-1.
//    S2: Wallace reduction of the matrix to carry-save pair (sum,carry) of PW bits via FA/HA layers.
//        Layers follow the Wallace 3:2 grouping rule.
//    S3: final carry-propagate add sum+carry, mod 2^PW -> out_prod.
//  - Latency: an operand accepted at edge k gives out_valid=1 after edge k+3, provided adv stays 1.
//    Each stall cycle adds exactly one cycle.
//  - Throughput 1/cycle when out_ready held 1; back-to-back results in order, no drops, no duplicates.
//  - Stall (out_valid & !out_ready): every stage holds. out_prod/out_valid stable until accepted.
//    in_ready=0.
//  - Bubbles: stage valid bits propagate with data. A bubble is never presented (out_valid=0 for it),
//    but it is not squeezed out during stall (global stall).
//  - Simultaneous out accept and in accept in the same cycle: legal, both occur.
//  - Reset mid-operation: all in-flight transactions discarded; no output after reset release
//    until a new accept.
//  - in_signed mixes freely between consecutive transactions; each result uses its own captured mode.
//  - Data regs of invalid stages may hold stale values; out_prod is only meaningful while out_valid=1.
// STRUCTURE
//  - Package wallace_pkg: localparam function pp_col_height(width, col).
//    Also: typedef/struct stage_t {logic v; logic sgn; logic [PW-1:0] s, c;}
//    and constant LATENCY=3.
//  - Sub-module csa_3to2 (parametrised bit-width carry-save row of full adders).
//    Instantiated per reduction layer via generate.
//  - Half adders reuse the existing HA cell.
//  - No other hierarchy; final adder is a behavioural '+'.
// TESTING
//  1. WIDTH=8, unsigned 255*255, out_ready=1 -> out_prod=16'hFE01, out_valid exactly 3 cycles after accept.
//  2. Signed -128*-128 -> 16'h4000. Signed -1*1 -> 16'hFFFF. Signed 127*-128 -> 16'hC080.
//     Unsigned 8'hFF*8'h01 -> 16'h00FF.
//  3. Stream 0..9 times 3 back-to-back, alternating in_signed, out_ready=1 -> ten products in order,
//     one per cycle, in_ready never 0.
//  4. Hold out_ready=0 for 5 cycles with 3 in flight -> in_ready=0, out_prod stable. On release,
//     3 results drain in order, none lost or duplicated.
//  5. Assert rst_n=0 mid-stream with 2 in flight -> out_valid=0, out_prod=0 immediately (async).
//     No stale result emerges after release.
//  6. Random 10k pairs, WIDTH in {2,5,8,16}, random valid/ready -> scoreboard vs $signed/$unsigned a*b.

Source files
------------

// File: rtl/wallace_mult_pipe_pkg.sv
// wallace_pkg: shared constants, stage record and elaboration-time helpers
// for the pipelined Wallace-tree multiplier.
//
//   LATENCY         edges from operand accept to result presentation
//   stage_t         record of one carry-save stage, sized for the widest
//                   legal operand (16 bits)
//   pp_col_height   bits per column of the partial-product matrix
//   rows_after      rows left after a number of 3:2 reduction layers
//   num_layers      3:2 layers needed to reach a carry-save pair
package wallace_pkg;

    localparam int LATENCY   = 3;
    localparam int WIDTH_MAX = 16;
    localparam int PW_MAX    = 2 * WIDTH_MAX;

    typedef struct packed {
        logic              v;
        logic              sgn;
        logic [PW_MAX-1:0] s;
        logic [PW_MAX-1:0] c;
    } stage_t;

    // Height of one column of a width x width AND-matrix. Signed mode adds
    // one constant bit at columns width and 2*width-1 on top of this.
    function automatic int pp_col_height(int width, int col);
        if (col < 0 || col >= 2 * width - 1) begin
            return 0;
        end
        if (col < width) begin
            return col + 1;
        end
        return 2 * width - 1 - col;
    endfunction

    // Every complete group of three rows becomes a sum row and a carry row;
    // the one or two leftover rows pass straight to the next layer.
    function automatic int rows_after(int n0, int layers);
        int n;
        n = n0;
        for (int k = 0; k < layers; k++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    function automatic int num_layers(int n0);
        int n;
        int l;
        n = n0;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/wallace_mult_pipe_csa_3to2.sv
// csa_3to2: one row of W full adders compressing three W-bit rows into a
// sum row and a carry row. The carry row is already weighted (shifted left
// by one), so x + y + z == o_sum + o_carry modulo 2^W.
//
// Ports
//   i_x, i_y, i_z   [W-1:0]  rows to compress
//   o_sum           [W-1:0]  bitwise sum
//   o_carry         [W-1:0]  carries, shifted into the next column
module csa_3to2
    import wallace_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_z,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    // The carry out of the top column falls off the product width, so only
    // the lower W-1 majority terms are formed.
    logic [W-2:0] w_maj;

    assign o_sum   = i_x ^ i_y ^ i_z;
    assign w_maj   = (i_x[W-2:0] & i_y[W-2:0])
                   | (i_x[W-2:0] & i_z[W-2:0])
                   | (i_y[W-2:0] & i_z[W-2:0]);
    assign o_carry = {w_maj, 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined WIDTH x WIDTH Wallace-tree multiplier with a
// valid/ready interface. Unsigned or two's-complement per transaction.
// A pair accepted at edge k is presented after edge k+3 when not stalled.
//
// Pipeline (all registers advance together on adv = !out_valid | out_ready)
//   S1  captured operands and mode
//   S2  partial-product matrix (Baugh-Wooley in signed mode)
//   S3  carry-save pair from the Wallace 3:2 reduction tree
//   out product after the final carry-propagate add
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready = adv
//   in_signed             1: operands are two's complement
//   in_a, in_b  [WIDTH]   multiplicand, multiplier
//   out_valid / out_ready product handshake
//   out_prod    [PW]      exact product
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int PW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_prod
);

    // WIDTH AND-rows plus one row carrying the Baugh-Wooley constants.
    localparam int NROWS   = WIDTH + 1;
    localparam int NLAYERS = num_layers(NROWS);

    logic                  w_adv;

    logic                  r_s1_v;
    logic                  r_s1_sgn;
    logic [WIDTH-1:0]      r_s1_a;
    logic [WIDTH-1:0]      r_s1_b;

    logic                  r_s2_v;
    logic [NROWS*PW-1:0]   r_s2_mat;

    logic                  r_s3_v;
    logic [PW-1:0]         r_s3_sum;
    logic [PW-1:0]         r_s3_carry;

    logic                  r_out_v;
    logic [PW-1:0]         r_out_prod;

    logic [NROWS*PW-1:0]   w_mat;
    logic [PW-1:0]         w_red_sum;
    logic [PW-1:0]         w_red_carry;
    logic [PW-1:0]         w_prod;

    // One stall signal for the whole pipe: bubbles are not squeezed out.
    assign w_adv     = !r_out_v || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_v;
    assign out_prod  = r_out_prod;

    // Row i holds a[j]&b[i] at column i+j. In signed mode the terms where
    // exactly one operand index is the MSB are inverted, and the extra row
    // supplies the two correction ones at columns WIDTH and PW-1.
    always_comb begin
        w_mat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                w_mat[i*PW + i + j] = (r_s1_a[j] & r_s1_b[i])
                                    ^ (r_s1_sgn & ((i == WIDTH-1) != (j == WIDTH-1)));
            end
        end
        if (r_s1_sgn) begin
            w_mat[WIDTH*PW + WIDTH]  = 1'b1;
            w_mat[WIDTH*PW + PW - 1] = 1'b1;
        end
    end

    // Wallace reduction: each layer groups its rows in threes through a
    // carry-save row; leftovers ride through unchanged. The tree always ends
    // with exactly two rows. Carries out of the top column are dropped,
    // which is safe because the true product fits in PW bits.
    for (genvar l = 0; l < NLAYERS; l++) begin : g_layer
        localparam int NI = rows_after(NROWS, l);
        localparam int NO = rows_after(NROWS, l + 1);
        localparam int NG = NI / 3;
        localparam int NP = NI % 3;

        logic [NI*PW-1:0] w_in;
        logic [NO*PW-1:0] w_out;

        if (l == 0) begin : g_src
            assign w_in = r_s2_mat;
        end else begin : g_src
            assign w_in = g_layer[l-1].w_out;
        end

        for (genvar g = 0; g < NG; g++) begin : g_csa
            csa_3to2 #(
                .W (PW)
            ) u_csa (
                .i_x     (w_in[(3*g)*PW   +: PW]),
                .i_y     (w_in[(3*g+1)*PW +: PW]),
                .i_z     (w_in[(3*g+2)*PW +: PW]),
                .o_sum   (w_out[(2*g)*PW   +: PW]),
                .o_carry (w_out[(2*g+1)*PW +: PW])
            );
        end

        for (genvar p = 0; p < NP; p++) begin : g_pass
            assign w_out[(2*NG+p)*PW +: PW] = w_in[(3*NG+p)*PW +: PW];
        end
    end

    assign w_red_sum   = g_layer[NLAYERS-1].w_out[PW-1:0];
    assign w_red_carry = g_layer[NLAYERS-1].w_out[2*PW-1:PW];

    assign w_prod = r_s3_sum + r_s3_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v     <= 1'b0;
            r_s1_sgn   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_v     <= 1'b0;
            r_s2_mat   <= '0;
            r_s3_v     <= 1'b0;
            r_s3_sum   <= '0;
            r_s3_carry <= '0;
            r_out_v    <= 1'b0;
            r_out_prod <= '0;
        end else if (w_adv) begin
            r_s1_v     <= in_valid;
            r_s1_sgn   <= in_signed;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
            r_s2_v     <= r_s1_v;
            r_s2_mat   <= w_mat;
            r_s3_v     <= r_s2_v;
            r_s3_sum   <= w_red_sum;
            r_s3_carry <= w_red_carry;
            r_out_v    <= r_s3_v;
            r_out_prod <= w_prod;
        end
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: four instances (WIDTH 2, 5, 8, 16), each with
// its own scoreboard. The WIDTH=8 instance also runs directed scenarios
// before the random phase starts on all four.
module tb_wallace_mult_pipe;

    localparam int NW    = 4;
    localparam int NRAND = 2500;

    function automatic int wsel(int i);
        case (i)
            0:       return 2;
            1:       return 5;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rand_done = 0;

    logic rand_go  = 1'b0;
    logic rst_main = 1'b0;
    logic rst8     = 1'b1;

    logic        d_valid  = 1'b0;
    logic        d_signed = 1'b0;
    logic        d_ready  = 1'b1;
    logic [7:0]  d_a      = '0;
    logic [7:0]  d_b      = '0;

    logic        o8_valid;
    logic        o8_in_ready;
    logic [15:0] o8_prod;
    int          cnt8 = 0;
    int          q8   = 0;

    function automatic void chk(bit ok, string name, longint act, longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    for (genvar gi = 0; gi < NW; gi++) begin : g_w
        localparam int W   = wsel(gi);
        localparam int P   = 2 * W;
        localparam bit DIR = (W == 8);

        logic         rst_n;
        logic         in_valid, in_ready, in_signed;
        logic         out_valid, out_ready;
        logic [W-1:0] in_a, in_b;
        logic [P-1:0] out_prod;

        logic         r_valid  = 1'b0;
        logic         r_signed = 1'b0;
        logic         r_ready  = 1'b1;
        logic [W-1:0] r_a = '0;
        logic [W-1:0] r_b = '0;

        logic [P-1:0] exp_q[$];
        int           ocnt = 0;
        logic         prev_stall = 1'b0;
        logic [P-1:0] prev_prod = '0;

        if (DIR) begin : g_dir
            assign in_valid  = rand_go ? r_valid  : d_valid;
            assign in_signed = rand_go ? r_signed : d_signed;
            assign in_a      = rand_go ? r_a      : d_a;
            assign in_b      = rand_go ? r_b      : d_b;
            assign out_ready = rand_go ? r_ready  : d_ready;
            assign rst_n     = rst_main & rst8;
            assign o8_valid    = out_valid;
            assign o8_in_ready = in_ready;
            assign o8_prod     = out_prod;
            always @(negedge clk) begin
                #1;
                cnt8 = ocnt;
                q8   = exp_q.size();
            end
        end else begin : g_rnd
            assign in_valid  = r_valid;
            assign in_signed = r_signed;
            assign in_a      = r_a;
            assign in_b      = r_b;
            assign out_ready = r_ready;
            assign rst_n     = rst_main;
        end

        wallace_mult_pipe #(
            .WIDTH (W)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_signed (in_signed),
            .in_a      (in_a),
            .in_b      (in_b),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_prod  (out_prod)
        );

        // Reference: plain integer multiply, truncated to the product width.
        function automatic logic [P-1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic s);
            longint pa, pb, p;
            if (s) begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
            end else begin
                pa = longint'(a);
                pb = longint'(b);
            end
            p = pa * pb;
            return p[P-1:0];
        endfunction

        // Scoreboard: push the expected product on accept, pop on presentation.
        always @(negedge clk) begin
            logic [P-1:0] e;
            if (!rst_n) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk(out_valid === 1'b1 && out_prod === prev_prod,
                        $sformatf("W%0d stall_hold", W), longint'(out_prod), longint'(prev_prod));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, $sformatf("W%0d unexpected_output", W), longint'(out_prod), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(out_prod === e, $sformatf("W%0d product", W),
                            longint'(out_prod), longint'(e));
                    end
                    ocnt++;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(in_a, in_b, in_signed));
                end
                prev_stall = out_valid && !out_ready;
                prev_prod  = out_prod;
            end
        end

        // Random driver: operands held until accepted, random valid and ready.
        initial begin
            int n;
            bit acc;
            n = 0;
            wait (rand_go);
            while (n < NRAND) begin
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (acc) n++;
                if (!r_valid || acc) begin
                    r_valid  = ($urandom_range(0, 3) != 0) && (n < NRAND);
                    r_a      = W'($urandom);
                    r_b      = W'($urandom);
                    r_signed = $urandom_range(0, 1) == 1;
                end
                r_ready = $urandom_range(0, 2) != 0;
            end
            r_valid = 1'b0;
            r_ready = 1'b1;
            repeat (10) @(posedge clk);
            @(negedge clk);
            #2;
            chk(exp_q.size() == 0, $sformatf("W%0d drain", W), exp_q.size(), 0);
            rand_done++;
        end
    end

    // Single transaction on the WIDTH=8 instance: checks latency and value.
    task automatic one_shot(input logic [7:0] a, input logic [7:0] b, input logic s,
                            input logic [15:0] exp, input string name);
        bit ok;
        int lat;
        d_a = a; d_b = b; d_signed = s; d_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (o8_in_ready) begin ok = 1'b1; break; end
        end
        chk(ok, {name, " accept"}, ok, 1);
        @(posedge clk);
        #1 d_valid = 1'b0;
        ok = 1'b0;
        lat = 0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (o8_valid) begin ok = 1'b1; break; end
        end
        chk(ok && lat == 3, {name, " latency"}, lat, 3);
        chk(o8_prod === exp, {name, " value"}, o8_prod, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
        d_a = a; d_b = b; d_signed = s; d_valid = 1'b1;
        @(negedge clk);
        chk(o8_in_ready === 1'b1, "send in_ready", o8_in_ready, 1);
        @(posedge clk);
        #1 d_valid = 1'b0;
    endtask

    task automatic wait_out8(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (o8_valid) begin ok = 1'b1; break; end
        end
        chk(ok, {name, " out_valid"}, ok, 1);
    endtask

    initial begin
        int start;
        logic [15:0] held;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk(o8_valid === 1'b0, "reset out_valid", o8_valid, 0);
        chk(o8_prod === 16'h0000, "reset out_prod", o8_prod, 0);
        chk(o8_in_ready === 1'b1, "reset in_ready", o8_in_ready, 1);
        rst_main = 1'b1;
        @(posedge clk);
        #1;

        // Directed products
        one_shot(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255");
        one_shot(8'h80, 8'h80, 1'b1, 16'h4000, "s-128x-128");
        one_shot(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s-1x1");
        one_shot(8'h7F, 8'h80, 1'b1, 16'hC080, "s127x-128");
        one_shot(8'hFF, 8'h01, 1'b0, 16'h00FF, "uFFx01");
        one_shot(8'h00, 8'hA5, 1'b1, 16'h0000, "s0xA5");

        // Back-to-back stream, alternating mode
        start = cnt8;
        for (int i = 0; i < 10; i++) begin
            d_a = 8'(i); d_b = 8'd3; d_signed = i[0]; d_valid = 1'b1;
            @(negedge clk);
            chk(o8_in_ready === 1'b1, "stream in_ready", o8_in_ready, 1);
            @(posedge clk);
            #1;
        end
        d_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 chk(cnt8 - start == 9, "stream count_k11", cnt8 - start, 9);
        @(posedge clk);
        @(negedge clk);
        #2 chk(cnt8 - start == 10, "stream count_k12", cnt8 - start, 10);
        chk(q8 == 0, "stream queue_empty", q8, 0);

        // Backpressure with three in flight
        @(posedge clk);
        #1 d_ready = 1'b0;
        start = cnt8;
        send8(8'h9C, 8'h37, 1'b1);
        send8(8'hE1, 8'hF0, 1'b0);
        send8(8'h05, 8'hFB, 1'b1);
        wait_out8("stall");
        held = o8_prod;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk(o8_in_ready === 1'b0, "stall in_ready", o8_in_ready, 0);
            chk(o8_prod === held, "stall out_prod", o8_prod, held);
        end
        chk(cnt8 == start, "stall no_consume", cnt8 - start, 0);
        @(posedge clk);
        #1 d_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 chk(cnt8 - start == 3, "drain count", cnt8 - start, 3);
        chk(q8 == 0, "drain queue_empty", q8, 0);

        // Reset with two in flight, one already presented and stalled
        @(posedge clk);
        #1 d_ready = 1'b0;
        send8(8'h11, 8'h22, 1'b0);
        send8(8'h33, 8'h44, 1'b1);
        wait_out8("rst_mid");
        @(posedge clk);
        #2 rst8 = 1'b0;
        #1;
        chk(o8_valid === 1'b0, "rst_mid out_valid", o8_valid, 0);
        chk(o8_prod === 16'h0000, "rst_mid out_prod", o8_prod, 0);
        chk(o8_in_ready === 1'b1, "rst_mid in_ready", o8_in_ready, 1);
        @(posedge clk);
        #1 rst8 = 1'b1;
        d_ready = 1'b1;
        start = cnt8;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2 chk(cnt8 == start, "rst_mid no_stale", cnt8 - start, 0);

        // Random phase on all widths
        @(posedge clk);
        #1 rand_go = 1'b1;
        for (int t = 0; t < 60000; t++) begin
            if (rand_done == NW) break;
            @(posedge clk);
        end
        chk(rand_done == NW, "random timeout", rand_done, NW);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
